// File: rtl/uart_rx_fifo_if.sv
// Character handshake between the UART receiver, the receive FIFO and the bus side.
// Both directions are valid/ready: a transfer happens on a rising clk_i edge where valid and ready are both high.
interface uart_rx_fifo_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready;

    modport master (
        output wr_data,
        output wr_valid,
        input  wr_ready,
        input  rd_data,
        input  rd_valid,
        output rd_ready
    );

    modport slave (
        input  wr_data,
        input  wr_valid,
        output wr_ready,
        output rd_data,
        output rd_valid,
        input  rd_ready
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver: first-word-fall-through storage plus
// 16550-style status (fill trigger, character timeout, sticky overrun).
module uart_rx_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       cfg_en_i,
    input  logic [15:0]                cfg_div_i,
    input  logic [1:0]                 cfg_trig_i,
    input  logic                       cfg_tmo_en_i,
    input  logic                       flush_i,
    input  logic                       rx_busy_i,
    uart_rx_fifo_if.slave              fifo_if,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       trig_o,
    output logic                       tmo_o,
    output logic                       ovr_o,
    input  logic                       ovr_clr_i
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [5:0] LAST_BIT = 6'd39;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PW-1:0]     wptr_q, wptr_d;
    logic [PW-1:0]     rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              ovr_q, ovr_d;
    logic              tmo_q, tmo_d;
    logic [15:0]       presc_q, presc_d;
    logic [5:0]        bitcnt_q, bitcnt_d;

    logic              flush;
    logic              push;
    logic              pop;
    logic              ovr_set;
    logic              tmr_rst;
    logic              bit_tick;
    logic [CW-1:0]     trig_lvl;

    // Disabling the block behaves exactly like holding flush.
    assign flush   = flush_i | ~cfg_en_i;
    assign pop     = fifo_if.rd_valid & fifo_if.rd_ready;
    assign push    = fifo_if.wr_valid & (~full_o | pop);
    assign ovr_set = fifo_if.wr_valid & full_o & ~pop;

    assign fifo_if.wr_ready = 1'b1;
    assign fifo_if.rd_valid = ~empty_o;
    assign fifo_if.rd_data  = mem_q[rptr_q];

    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign trig_o  = (count_q >= trig_lvl);
    assign tmo_o   = tmo_q;
    assign ovr_o   = ovr_q;

    always_comb begin
        trig_lvl = CW'(1);
        case (cfg_trig_i)
            2'd0:    trig_lvl = CW'(1);
            2'd1:    trig_lvl = CW'(DEPTH / 4);
            2'd2:    trig_lvl = CW'(DEPTH / 2);
            default: trig_lvl = CW'(DEPTH - 2);
        endcase
    end

    always_comb begin
        mem_d = mem_q;
        if (push && !flush) begin
            mem_d[wptr_q] = fifo_if.wr_data;
        end
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                wptr_d = wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // A new overrun in the same cycle as a clear must stay visible.
    always_comb begin
        ovr_d = ovr_q;
        if (ovr_clr_i) begin
            ovr_d = 1'b0;
        end
        if (ovr_set) begin
            ovr_d = 1'b1;
        end
    end

    // The >= compare lets a lowered divider take effect on the very next wrap.
    assign bit_tick = (presc_q >= cfg_div_i);
    assign tmr_rst  = push | pop | flush | empty_o | rx_busy_i | ~cfg_tmo_en_i;

    always_comb begin
        presc_d  = presc_q;
        bitcnt_d = bitcnt_q;
        tmo_d    = tmo_q;
        if (tmr_rst) begin
            presc_d  = '0;
            bitcnt_d = '0;
            tmo_d    = 1'b0;
        end else if (!tmo_q) begin
            if (bit_tick) begin
                presc_d = '0;
                if (bitcnt_q == LAST_BIT) begin
                    tmo_d = 1'b1;
                end else begin
                    bitcnt_d = bitcnt_q + 6'd1;
                end
            end else begin
                presc_d = presc_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            ovr_q    <= 1'b0;
            tmo_q    <= 1'b0;
            presc_q  <= '0;
            bitcnt_q <= '0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            ovr_q    <= ovr_d;
            tmo_q    <= tmo_d;
            presc_q  <= presc_d;
            bitcnt_q <= bitcnt_d;
        end
    end

    // Storage carries no reset; stale contents are never visible while empty.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized and directed bench for uart_rx_fifo, checked every cycle against a
// queue-based model of the receive buffer and its status flags.
module tb_uart_rx_fifo;

    localparam int DEPTH  = 16;
    localparam int DATA_W = 8;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic          clk_i = 1'b0;
    logic          rst_n_i;
    logic          cfg_en_i;
    logic [15:0]   cfg_div_i;
    logic [1:0]    cfg_trig_i;
    logic          cfg_tmo_en_i;
    logic          flush_i;
    logic          rx_busy_i;
    logic [CW-1:0] count_o;
    logic          full_o;
    logic          empty_o;
    logic          trig_o;
    logic          tmo_o;
    logic          ovr_o;
    logic          ovr_clr_i;

    uart_rx_fifo_if #(.DATA_W(DATA_W)) bus ();

    uart_rx_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .cfg_en_i     (cfg_en_i),
        .cfg_div_i    (cfg_div_i),
        .cfg_trig_i   (cfg_trig_i),
        .cfg_tmo_en_i (cfg_tmo_en_i),
        .flush_i      (flush_i),
        .rx_busy_i    (rx_busy_i),
        .fifo_if      (bus),
        .count_o      (count_o),
        .full_o       (full_o),
        .empty_o      (empty_o),
        .trig_o       (trig_o),
        .tmo_o        (tmo_o),
        .ovr_o        (ovr_o),
        .ovr_clr_i    (ovr_clr_i)
    );

    // ---------------- clock ----------------
    always #5 clk_i = ~clk_i;

    // ---------------- scoreboard / counters ----------------
    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DATA_W-1:0] exp_q[$];
    bit  m_ovr;
    int  m_idle;
    bit  m_full, m_pop, m_push, m_flush, m_trst;

    function automatic int trig_thr(input logic [1:0] t);
        case (t)
            2'd0:    return 1;
            2'd1:    return DEPTH / 4;
            2'd2:    return DEPTH / 2;
            default: return DEPTH - 2;
        endcase
    endfunction

    initial begin
        exp_q.delete();
        m_ovr  = 1'b0;
        m_idle = 0;
        forever begin
            @(posedge clk_i or negedge rst_n_i);
            if (!rst_n_i) begin
                exp_q.delete();
                m_ovr  = 1'b0;
                m_idle = 0;
            end else begin
                m_full  = (exp_q.size() == DEPTH);
                m_pop   = (exp_q.size() > 0) && bus.rd_ready;
                m_push  = bus.wr_valid && (!m_full || m_pop);
                m_flush = flush_i || !cfg_en_i;
                m_trst  = m_push || m_pop || m_flush || (exp_q.size() == 0) ||
                          rx_busy_i || !cfg_tmo_en_i;
                if (bus.wr_valid && m_full && !m_pop) m_ovr = 1'b1;
                else if (ovr_clr_i)                   m_ovr = 1'b0;
                if (m_flush) begin
                    exp_q.delete();
                end else begin
                    if (m_pop)  void'(exp_q.pop_front());
                    if (m_push) exp_q.push_back(bus.wr_data);
                end
                if (m_trst)              m_idle = 0;
                else if (m_idle < 100000) m_idle = m_idle + 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk_i);
            if (chk_en) begin
                chk("count",    32'(count_o),      32'(exp_q.size()));
                chk("empty",    32'(empty_o),      32'(exp_q.size() == 0));
                chk("full",     32'(full_o),       32'(exp_q.size() == DEPTH));
                chk("rd_valid", 32'(bus.rd_valid), 32'(exp_q.size() != 0));
                chk("wr_ready", 32'(bus.wr_ready), 32'd1);
                chk("trig",     32'(trig_o),       32'(exp_q.size() >= trig_thr(cfg_trig_i)));
                chk("tmo",      32'(tmo_o),        32'(m_idle >= 40 * (int'(cfg_div_i) + 1)));
                chk("ovr",      32'(ovr_o),        32'(m_ovr));
                if (exp_q.size() != 0) begin
                    chk("rd_data", 32'(bus.rd_data), 32'(exp_q[0]));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [DATA_W-1:0] b);
        bus.wr_valid = 1'b1;
        bus.wr_data  = b;
        step();
        bus.wr_valid = 1'b0;
    endtask

    task automatic pop_one();
        bus.rd_ready = 1'b1;
        step();
        bus.rd_ready = 1'b0;
    endtask

    task automatic do_flush();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_count"},    32'(count_o),      32'd0);
        chk({tag, "_empty"},    32'(empty_o),      32'd1);
        chk({tag, "_full"},     32'(full_o),       32'd0);
        chk({tag, "_rd_valid"}, 32'(bus.rd_valid), 32'd0);
        chk({tag, "_trig"},     32'(trig_o),       32'd0);
        chk({tag, "_tmo"},      32'(tmo_o),        32'd0);
        chk({tag, "_ovr"},      32'(ovr_o),        32'd0);
        chk({tag, "_wr_ready"}, 32'(bus.wr_ready), 32'd1);
    endtask

    // ---------------- main stimulus ----------------
    initial begin
        rst_n_i      = 1'b0;
        cfg_en_i     = 1'b1;
        cfg_div_i    = 16'd3;
        cfg_trig_i   = 2'd2;
        cfg_tmo_en_i = 1'b0;
        flush_i      = 1'b0;
        rx_busy_i    = 1'b0;
        ovr_clr_i    = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.rd_ready = 1'b0;

        step();
        chk_reset_vals("reset");
        step();
        rst_n_i = 1'b1;
        chk_en  = 1'b1;
        step();

        // In-order fall-through.
        push(8'h41);
        push(8'h42);
        push(8'h43);
        chk("t1_count", 32'(count_o), 32'd3);
        chk("t1_head",  32'(bus.rd_data), 32'h41);
        for (int i = 0; i < 3; i++) begin
            chk("t1_pop_data", 32'(bus.rd_data), 32'(8'h41 + i));
            pop_one();
        end
        chk("t1_empty", 32'(empty_o), 32'd1);

        // Trigger levels.
        cfg_trig_i = 2'd2;
        for (int i = 1; i <= 8; i++) begin
            push(8'(i));
            if (i == 7) chk("t2_trig_at7", 32'(trig_o), 32'd0);
            if (i == 8) chk("t2_trig_at8", 32'(trig_o), 32'd1);
        end
        pop_one();
        chk("t2_trig_after_pop", 32'(trig_o), 32'd0);
        cfg_trig_i = 2'd3;
        for (int i = 9; i <= 14; i++) push(8'(i));
        chk("t2_trig_at13", 32'(trig_o), 32'd0);
        push(8'd15);
        chk("t2_trig_at14", 32'(trig_o), 32'd1);

        // Overrun while full.
        push(8'd16);
        push(8'd17);
        chk("t3_full", 32'(full_o), 32'd1);
        push(8'h55);
        chk("t3_ovr_count", 32'(count_o), 32'd16);
        chk("t3_ovr_set",   32'(ovr_o),   32'd1);
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'h66;
        bus.rd_ready = 1'b1;
        step();
        bus.wr_valid = 1'b0;
        bus.rd_ready = 1'b0;
        chk("t3_pushpop_count", 32'(count_o), 32'd16);
        chk("t3_pushpop_ovr",   32'(ovr_o),   32'd1);
        chk("t3_pushpop_head",  32'(bus.rd_data), 32'd3);
        ovr_clr_i = 1'b1;
        step();
        ovr_clr_i = 1'b0;
        chk("t3_ovr_clr", 32'(ovr_o), 32'd0);

        // Character timeout with cfg_div_i=3: 160 clocks.
        do_flush();
        chk("t4_flush_count", 32'(count_o), 32'd0);
        cfg_tmo_en_i = 1'b1;
        cfg_div_i    = 16'd3;
        push(8'hA0);
        repeat (159) step();
        chk("t4_tmo_159", 32'(tmo_o), 32'd0);
        step();
        chk("t4_tmo_160", 32'(tmo_o), 32'd1);
        pop_one();
        chk("t4_tmo_pop", 32'(tmo_o), 32'd0);
        rx_busy_i = 1'b1;
        push(8'hA1);
        repeat (200) step();
        chk("t4_tmo_busy", 32'(tmo_o), 32'd0);
        rx_busy_i = 1'b0;
        pop_one();
        cfg_tmo_en_i = 1'b0;

        // Pointer wrap-around.
        do_flush();
        for (int i = 0; i < 40; i++) begin
            push(8'(8'hC0 + i));
            chk("t5_count1", 32'(count_o), 32'd1);
            chk("t5_data",   32'(bus.rd_data), 32'(8'(8'hC0 + i)));
            pop_one();
        end
        chk("t5_empty", 32'(empty_o), 32'd1);

        // Flush mid-operation keeps the overrun flag.
        for (int i = 0; i < 17; i++) push(8'(i));
        do_flush();
        for (int i = 0; i < 5; i++) push(8'(8'h30 + i));
        chk("t6_count5", 32'(count_o), 32'd5);
        flush_i      = 1'b1;
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'h77;
        step();
        flush_i      = 1'b0;
        bus.wr_valid = 1'b0;
        chk("t6_count", 32'(count_o), 32'd0);
        chk("t6_empty", 32'(empty_o), 32'd1);
        chk("t6_tmo",   32'(tmo_o),   32'd0);
        chk("t6_ovr",   32'(ovr_o),   32'd1);
        ovr_clr_i = 1'b1;
        step();
        ovr_clr_i = 1'b0;

        // Randomized traffic with an asynchronous reset mid-stream.
        for (int i = 0; i < 3200; i++) begin
            int phase;
            int wr_pct;
            int rd_pct;
            phase = (i / 200) % 4;
            if (i % 400 == 0) begin
                bus.wr_valid = 1'b0;
                bus.rd_ready = 1'b0;
                cfg_div_i    = 16'($urandom_range(0, 1));
                cfg_trig_i   = 2'($urandom_range(0, 3));
                cfg_tmo_en_i = ($urandom_range(0, 3) != 0);
                do_flush();
                continue;
            end
            if (i == 1700) begin
                @(posedge clk_i);
                #3;
                rst_n_i = 1'b0;
                #1;
                chk_reset_vals("async_rst");
                bus.wr_valid = 1'b0;
                bus.rd_ready = 1'b0;
                step();
                step();
                rst_n_i = 1'b1;
                continue;
            end
            case (phase)
                0:       begin wr_pct = 80; rd_pct = 20; end
                1:       begin wr_pct = 20; rd_pct = 80; end
                2:       begin wr_pct = 2;  rd_pct = 1;  end
                default: begin wr_pct = 50; rd_pct = 50; end
            endcase
            cfg_en_i     = ($urandom_range(0, 99) != 0);
            bus.wr_valid = ($urandom_range(0, 99) < wr_pct) && cfg_en_i;
            bus.wr_data  = 8'($urandom);
            bus.rd_ready = ($urandom_range(0, 99) < rd_pct);
            rx_busy_i    = (phase != 2) && ($urandom_range(0, 99) < 5);
            ovr_clr_i    = ($urandom_range(0, 99) < 2);
            step();
        end
        cfg_en_i     = 1'b1;
        bus.wr_valid = 1'b0;
        bus.rd_ready = 1'b0;
        rx_busy_i    = 1'b0;
        ovr_clr_i    = 1'b0;
        step();
        step();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
